mac_pipe_scheduler: RTL and testbench
=====================================

# mac_pipe_scheduler

Round-robin scheduler that shares one 3-stage pipelined add-multiply-accumulate datapath, `out = ((a + b) * c) + acc`, between `NUM_REQ` requesters. It keeps one accumulator register per requester and feeds the datapath its operands on the required skewed cycles. It routes each result back to its owner and writes it into that requester's accumulator. It sits between requester-side valid/ready ports and the datapath instance, which lives outside this block.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `WIDTH`, default 16: operand, accumulator and result width.
- `clk`, in, 1: single clock; all logic is on its rising edge.
- `rst_n`, in, 1: reset, asynchronous assert, active-low.
- `req_valid`, in, `NUM_REQ`: per-requester operation request.
- `req_ready`, out, `NUM_REQ`: per-requester accept; one-hot or zero.
- `req_a`, `req_b`, `req_c`, in, `NUM_REQ*WIDTH` each: operands, flattened, requester `r` at bits `[r*WIDTH +: WIDTH]`.
- `dp_a`, `dp_b`, `dp_c`, `dp_acc`, out, `WIDTH` each: datapath operand inputs.
- `dp_out`, in, `WIDTH`: datapath result.
- `res_valid`, out, 1: result strobe.
- `res_id`, out, `$clog2(NUM_REQ)`: owner of the result.
- `res_data`, out, `WIDTH`: result value, equal to `dp_out`.
- `acc_out`, out, `NUM_REQ*WIDTH`: current accumulator contents, flattened.

## Operation
- Handshake: an operation is accepted in the cycle where `req_valid[r] && req_ready[r]`.
  - `req_ready` may depend combinationally on `req_valid`.
  - Requesters must not make `req_valid` depend on `req_ready`.
  - Once asserted, `req_valid` and its operands are held until accepted.
- Eligibility: requester `r` is eligible when `req_valid[r] && !pending[r]`.
- Arbitration: round-robin over eligible requesters.
  - Search starts at `ptr`, which resets to 0.
  - On a grant, `ptr` becomes grant+1 mod `NUM_REQ`.
  - `req_ready` is high only for the granted requester. At most one accept per cycle.
- `pending[r]` is set at the accept edge and cleared at the edge that ends `r`'s `res_valid` cycle. A requester therefore never has two operations in flight, so there is no accumulator hazard.
- Tag pipeline: stage tags {valid, id} shift every cycle, and an empty slot carries valid=0. The datapath has no stall, so nothing in this block stalls.
- Results:
  - `res_valid` = tag valid at stage 4. `res_id` = tag id.
  - `acc[res_id] <= dp_out` on the same edge.
- Arithmetic: all sums and products are truncated modulo 2^`WIDTH` (unsigned wrap).
- Reset, including mid-operation:
  - All tags invalid, `pending` = 0, `ptr` = 0, every `acc` = 0.
  - `dp_*` = 0, `res_valid` = 0, `req_ready` = 0.
  - In-flight operations are discarded. Datapath output that is still draining is ignored because its tags are invalid.

## Timing
- Cycle k is the interval after clock edge k. The accept happens in cycle 0.
- The operands must be skewed to match the datapath stages:
  - Cycle 1: `dp_a`, `dp_b` hold the accepted a and b (registered).
  - Cycle 2: `dp_c` holds c (delayed one stage).
  - Cycle 3: `dp_acc` holds `acc[id]` read in that cycle.
  - Cycle 4: `dp_out` is valid; `res_valid`, `res_id`, `res_data` are asserted.
  - Cycle 5: `acc_out` shows the new value; `pending[id]` is clear, so `r` may be accepted again in cycle 5.
- Accept-to-result latency is 4 cycles.
- Aggregate throughput is 1 operation/cycle across distinct requesters. Per requester it is 1 operation every 5 cycles.
- `dp_*` hold their last value when there is no valid stage; the datapath output is ignored in that case.

## Configuration
- `MAC_SCHED_CLR_EN` defined:
  - Adds input `req_clr` (`NUM_REQ`), sampled at accept and carried in the tag.
  - A set clr bit forces `dp_acc` = 0 in cycle 3, so the result is a plain (a+b)*c that then becomes the new accumulator.
- `MAC_SCHED_CLR_EN` undefined: the port and the tag bit are absent, and `dp_acc` is always `acc[id]`.

## Structure
- Package `mac_sched_pkg`:
  - Tag struct `mac_sched_tag_t` {valid, id, clr}.
  - Localparams for stage offsets: `A_STAGE`=1, `C_STAGE`=2, `ACC_STAGE`=3, `RES_STAGE`=4.
- Sub-module `mac_sched_rr_arb`:
  - Parameter `NUM_REQ`.
  - Inputs: eligible vector, accept.
  - Outputs: one-hot grant, `ptr` state.

## Test plan
- Single requester, accumulate:
  - After reset, r0 sends a=2, b=3, c=4, accepted in cycle 0 → cycle 4: `res_valid`=1, `res_id`=0, `res_data`=20; cycle 5: `acc_out[0]`=20.
  - Then a=1, b=1, c=5 → `res_data`=30.
- Four requesters all valid from reset → grants r0, r1, r2, r3 in cycles 0..3; results in cycles 4..7 in the same order.
- r0 holds `req_valid` continuously → `req_ready[0]` is low in cycles 1..4, and the next accept is in cycle 5.
- Wrap: `acc[2]`=0xFFF0, r2 sends a=0, b=1, c=0x20 → `res_data`=0x0010.
- Reset pulse in cycle 2 with an operation in flight → no `res_valid` after release, all `acc_out`=0, `req_ready` resumes granting from r0.
- With `MAC_SCHED_CLR_EN`: `acc[0]`=20, r0 sends clr=1, a=1, b=1, c=3 → `res_data`=6, `acc_out[0]`=6.

Source files
------------

// File: rtl/mac_sched_pkg.sv
// Shared types and stage offsets for the MAC pipeline scheduler.
// Optional feature: MAC_SCHED_CLR_EN adds a per-operation accumulator clear bit to the tag.
package mac_sched_pkg;

  localparam int unsigned A_STAGE   = 1;
  localparam int unsigned C_STAGE   = 2;
  localparam int unsigned ACC_STAGE = 3;
  localparam int unsigned RES_STAGE = 4;

  // Sized for the largest supported requester count (16).
  localparam int unsigned MAX_ID_W = 4;

  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
`ifdef MAC_SCHED_CLR_EN
    logic                clr;
`endif
  } mac_sched_tag_t;

endpackage

// File: rtl/mac_sched_rr_arb.sv
// Round-robin arbiter: one-hot grant among eligible requesters, searching from ptr.
module mac_sched_rr_arb #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         eligible,
  input  logic                       accept,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] ptr
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0] next_ptr;
  logic            found;
  int unsigned     idx;

  always_comb begin
    grant    = '0;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(ptr) + i) % NUM_REQ;
      if (!found && eligible[ID_W'(idx)]) begin
        found              = 1'b1;
        grant[ID_W'(idx)]  = 1'b1;
        next_ptr           = ID_W'((idx + 1) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ptr <= '0;
    else if (accept)
      ptr <= next_ptr;
  end

endmodule

// File: rtl/mac_pipe_scheduler.sv
// Shares one 3-stage (a+b)*c+acc datapath among NUM_REQ requesters with per-requester accumulators.
// Optional feature: define MAC_SCHED_CLR_EN to add req_clr (forces dp_acc to zero for that operation).
module mac_pipe_scheduler
  import mac_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  input  logic [NUM_REQ*WIDTH-1:0]   req_c,
`ifdef MAC_SCHED_CLR_EN
  input  logic [NUM_REQ-1:0]         req_clr,
`endif
  output logic [WIDTH-1:0]           dp_a,
  output logic [WIDTH-1:0]           dp_b,
  output logic [WIDTH-1:0]           dp_c,
  output logic [WIDTH-1:0]           dp_acc,
  input  logic [WIDTH-1:0]           dp_out,
  output logic                       res_valid,
  output logic [$clog2(NUM_REQ)-1:0] res_id,
  output logic [WIDTH-1:0]           res_data,
  output logic [NUM_REQ*WIDTH-1:0]   acc_out
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] pending;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] ret_mask;
  logic [ID_W-1:0]    grant_id;
  logic [ID_W-1:0]    arb_ptr;
  logic               accept;
  logic [WIDTH-1:0]   c_q;
  logic [WIDTH-1:0]   acc_sel;
  logic [WIDTH-1:0]   acc [NUM_REQ];
  mac_sched_tag_t     tag [A_STAGE:RES_STAGE];
  logic               unused_bits;

  assign eligible  = rst_n ? (req_valid & ~pending) : '0;
  assign accept    = |grant;
  assign req_ready = grant;

  mac_sched_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .eligible (eligible),
    .accept   (accept),
    .grant    (grant),
    .ptr      (arb_ptr)
  );

  always_comb begin
    grant_id = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++)
      if (grant[i]) grant_id = ID_W'(i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag[A_STAGE]   <= '0;
      tag[C_STAGE]   <= '0;
      tag[ACC_STAGE] <= '0;
      tag[RES_STAGE] <= '0;
    end else begin
      tag[A_STAGE].valid <= accept;
      tag[A_STAGE].id    <= MAX_ID_W'(grant_id);
`ifdef MAC_SCHED_CLR_EN
      tag[A_STAGE].clr   <= req_clr[grant_id];
`endif
      tag[C_STAGE]   <= tag[A_STAGE];
      tag[ACC_STAGE] <= tag[C_STAGE];
      tag[RES_STAGE] <= tag[ACC_STAGE];
    end
  end

  // acc[id] is sampled one cycle early and registered; pending[id] blocks any
  // write to it before the result, so dp_acc still equals acc[id] in its cycle.
  always_comb begin
    acc_sel = acc[tag[C_STAGE].id[ID_W-1:0]];
`ifdef MAC_SCHED_CLR_EN
    if (tag[C_STAGE].clr) acc_sel = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_a   <= '0;
      dp_b   <= '0;
      dp_c   <= '0;
      dp_acc <= '0;
      c_q    <= '0;
    end else begin
      if (accept) begin
        dp_a <= req_a[grant_id*WIDTH +: WIDTH];
        dp_b <= req_b[grant_id*WIDTH +: WIDTH];
        c_q  <= req_c[grant_id*WIDTH +: WIDTH];
      end
      if (tag[A_STAGE].valid) dp_c   <= c_q;
      if (tag[C_STAGE].valid) dp_acc <= acc_sel;
    end
  end

  assign res_valid = tag[RES_STAGE].valid;
  assign res_id    = tag[RES_STAGE].id[ID_W-1:0];
  assign res_data  = dp_out;

  always_comb begin
    ret_mask = '0;
    if (res_valid) ret_mask[res_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) acc[i] <= '0;
    end else begin
      pending <= (pending | grant) & ~ret_mask;
      if (res_valid) acc[res_id] <= dp_out;
    end
  end

  always_comb begin
    acc_out = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) acc_out[i*WIDTH +: WIDTH] = acc[i];
  end

  assign unused_bits = ^{arb_ptr, tag[RES_STAGE], tag[C_STAGE]};

endmodule

// File: tb/tb_mac_pipe_scheduler.sv
// Bench for mac_pipe_scheduler: behavioural datapath plus a transaction-level scheduler model.
module tb_mac_pipe_scheduler;

  localparam int N = 4;
  localparam int W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_a = '0, req_b = '0, req_c = '0;
`ifdef MAC_SCHED_CLR_EN
  logic [N-1:0]     req_clr = '0;
`endif
  logic [W-1:0]     dp_a, dp_b, dp_c, dp_acc, dp_out;
  logic             res_valid;
  logic [1:0]       res_id;
  logic [W-1:0]     res_data;
  logic [N*W-1:0]   acc_out;

  mac_pipe_scheduler #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_c     (req_c),
`ifdef MAC_SCHED_CLR_EN
    .req_clr   (req_clr),
`endif
    .dp_a      (dp_a),
    .dp_b      (dp_b),
    .dp_c      (dp_c),
    .dp_acc    (dp_acc),
    .dp_out    (dp_out),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_data  (res_data),
    .acc_out   (acc_out)
  );

  always #5 clk = ~clk;

  // External 3-stage datapath: (a+b) -> *c -> +acc.
  logic [W-1:0] s1, s2;
  always @(posedge clk) begin
    s1     <= dp_a + dp_b;
    s2     <= s1 * dp_c;
    dp_out <= s2 + dp_acc;
  end

  typedef struct { logic [W-1:0] a, b, c; logic clr; } op_t;
  typedef struct { int acc_cyc; int due; int id; logic [W-1:0] val; } ev_t;

  op_t      opq [N][$];
  ev_t      inflight [$];
  ev_t      mlog [$];
  int       cyc = 0;
  int       tests = 0, fails = 0;
  int       ptr_m = 0;
  bit       pend_m [N];
  logic [W-1:0] acc_m [N];
  int       grant_cnt [N];
  int       seen [N];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: round-robin over valid & not-pending, result due 4 cycles after accept.
  always @(negedge clk) begin : model
    int g;
    logic [N-1:0] exp_ready;
    logic [W-1:0] s, ac;
    if (!rst_n) begin
      ptr_m = 0;
      for (int r = 0; r < N; r++) begin
        pend_m[r] = 0;
        acc_m[r]  = '0;
        chk("rst_acc_out", acc_out[r*W +: W], '0);
      end
      inflight.delete();
      chk("rst_req_ready", req_ready, '0);
      chk("rst_res_valid", res_valid, 1'b0);
    end else begin
      g = -1;
      for (int i = 0; i < N; i++) begin
        int idx;
        idx = (ptr_m + i) % N;
        if (g < 0 && req_valid[idx] && !pend_m[idx]) g = idx;
      end
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      chk("req_ready", req_ready, exp_ready);

      if (inflight.size() > 0 && inflight[0].due == cyc) begin
        chk("res_valid", res_valid, 1'b1);
        chk("res_id", res_id, inflight[0].id);
        chk("res_data", res_data, inflight[0].val);
      end else begin
        chk("res_valid_idle", res_valid, 1'b0);
      end
      for (int r = 0; r < N; r++) chk("acc_out", acc_out[r*W +: W], acc_m[r]);

      if (inflight.size() > 0 && inflight[0].due == cyc) begin
        acc_m[inflight[0].id]  = inflight[0].val;
        pend_m[inflight[0].id] = 0;
        inflight.delete(0);
      end
      if (g >= 0) begin
        ev_t e;
        s  = req_a[g*W +: W] + req_b[g*W +: W];
        s  = s * req_c[g*W +: W];
        ac = acc_m[g];
`ifdef MAC_SCHED_CLR_EN
        if (req_clr[g]) ac = '0;
`endif
        s  = s + ac;
        e.acc_cyc = cyc; e.due = cyc + 4; e.id = g; e.val = s;
        inflight.push_back(e);
        mlog.push_back(e);
        pend_m[g] = 1;
        ptr_m = (g + 1) % N;
        grant_cnt[g]++;
      end
    end
  end

  task automatic drive();
    for (int r = 0; r < N; r++) begin
      if (opq[r].size() > 0) begin
        req_valid[r]     = 1'b1;
        req_a[r*W +: W]  = opq[r][0].a;
        req_b[r*W +: W]  = opq[r][0].b;
        req_c[r*W +: W]  = opq[r][0].c;
`ifdef MAC_SCHED_CLR_EN
        req_clr[r]       = opq[r][0].clr;
`endif
      end else begin
        req_valid[r] = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int r = 0; r < N; r++)
      while (seen[r] != grant_cnt[r]) begin
        if (opq[r].size() > 0) opq[r].delete(0);
        seen[r]++;
      end
    drive();
  endtask

  task automatic push(input int r, input logic [W-1:0] a, b, c, input logic clr);
    op_t o;
    o.a = a; o.b = b; o.c = c; o.clr = clr;
    opq[r].push_back(o);
    drive();
  endtask

  task automatic wait_idle(input int budget);
    int  n;
    bit  busy;
    n = 0;
    do begin
      step();
      n++;
      busy = inflight.size() > 0;
      for (int r = 0; r < N; r++) if (opq[r].size() > 0) busy = 1;
    end while (busy && n < budget);
    if (busy) begin
      tests++; fails++;
      $display("FAIL wait_idle: still busy after %0d cycles, expected idle", budget);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int r = 0; r < N; r++) begin
      opq[r].delete();
      seen[r] = grant_cnt[r];
    end
    drive();
    step(); step(); step();
    rst_n = 1'b1;
  endtask

  int b;

  initial begin
    #1;
    do_reset();

    // Single requester accumulate: 20 then 30.
    b = mlog.size();
    push(0, 16'd2, 16'd3, 16'd4, 1'b0);
    wait_idle(50);
    chk("t1_model_val", mlog[b].val, 16'd20);
    chk("t1_acc0", acc_out[15:0], 16'd20);
    push(0, 16'd1, 16'd1, 16'd5, 1'b0);
    wait_idle(50);
    chk("t1b_acc0", acc_out[15:0], 16'd30);

    // Four requesters from reset: grants 0..3 in consecutive cycles.
    do_reset();
    b = mlog.size();
    for (int r = 0; r < N; r++) opq[r].push_back('{a: W'(r), b: 16'd1, c: 16'd2, clr: 1'b0});
    drive();
    wait_idle(50);
    for (int r = 0; r < N; r++) begin
      chk("t2_grant_id", mlog[b+r].id, r);
      chk("t2_grant_cyc", mlog[b+r].acc_cyc - mlog[b].acc_cyc, r);
      chk("t2_acc", acc_out[r*W +: W], 2*(r+1));
    end

    // r0 held valid: second accept 5 cycles after the first.
    b = mlog.size();
    push(0, 16'd1, 16'd0, 16'd1, 1'b0);
    push(0, 16'd2, 16'd2, 16'd1, 1'b0);
    wait_idle(50);
    chk("t3_reaccept_gap", mlog[b+1].acc_cyc - mlog[b].acc_cyc, 5);
    chk("t3_acc0", acc_out[15:0], 16'd7);

    // Wrap: acc[2]=0xFFF0 then (0+1)*0x20 -> 0x0010.
    do_reset();
    push(2, 16'hFFF0, 16'd0, 16'd1, 1'b0);
    push(2, 16'd0, 16'd1, 16'h20, 1'b0);
    wait_idle(50);
    chk("t4_model_wrap", mlog[mlog.size()-1].val, 16'h0010);
    chk("t4_acc2", acc_out[47:32], 16'h0010);

    // Reset in cycle 2 of an in-flight operation.
    push(3, 16'd1, 16'd1, 16'd1, 1'b0);
    b = grant_cnt[3];
    for (int i = 0; i < 20 && grant_cnt[3] == b; i++) step();
    chk("t5_accepted", grant_cnt[3] - b, 1);
    step();
    do_reset();
    for (int i = 0; i < 6; i++) step();
    chk("t5_acc_clear", acc_out, '0);
    b = mlog.size();
    push(1, 16'd1, 16'd2, 16'd3, 1'b0);
    push(0, 16'd2, 16'd2, 16'd2, 1'b0);
    wait_idle(50);
    chk("t5_first_grant", mlog[b].id, 0);
    chk("t5_second_grant", mlog[b+1].id, 1);
    chk("t5_acc1", acc_out[31:16], 16'd9);

`ifdef MAC_SCHED_CLR_EN
    do_reset();
    push(0, 16'd2, 16'd3, 16'd4, 1'b0);
    push(0, 16'd1, 16'd1, 16'd3, 1'b1);
    wait_idle(50);
    chk("t6_model_clr", mlog[mlog.size()-1].val, 16'd6);
    chk("t6_acc0", acc_out[15:0], 16'd6);
`endif

    step(); step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
